// File: rtl/ahbl_arbiter_2m.sv
// ahbl_arbiter_2m: two AHB-Lite masters onto one slave port.
// A losing request parks in a one-entry buffer for its master.
module ahbl_arbiter_2m #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W_ADDR-1:0] m0_haddr,
  input  logic              m0_hwrite,
  input  logic [1:0]        m0_htrans,
  input  logic              m0_hexcl,
  input  logic [2:0]        m0_hsize,
  input  logic [2:0]        m0_hburst,
  input  logic [3:0]        m0_hprot,
  input  logic              m0_hmastlock,
  input  logic [W_DATA-1:0] m0_hwdata,
  output logic              m0_hready,
  output logic              m0_hresp,
  output logic              m0_hexokay,
  output logic [W_DATA-1:0] m0_hrdata,
  input  logic [W_ADDR-1:0] m1_haddr,
  input  logic              m1_hwrite,
  input  logic [1:0]        m1_htrans,
  input  logic              m1_hexcl,
  input  logic [2:0]        m1_hsize,
  input  logic [2:0]        m1_hburst,
  input  logic [3:0]        m1_hprot,
  input  logic              m1_hmastlock,
  input  logic [W_DATA-1:0] m1_hwdata,
  output logic              m1_hready,
  output logic              m1_hresp,
  output logic              m1_hexokay,
  output logic [W_DATA-1:0] m1_hrdata,
  output logic [W_ADDR-1:0] s_haddr,
  output logic              s_hwrite,
  output logic [1:0]        s_htrans,
  output logic              s_hexcl,
  output logic [2:0]        s_hsize,
  output logic [2:0]        s_hburst,
  output logic [3:0]        s_hprot,
  output logic              s_hmastlock,
  output logic [W_DATA-1:0] s_hwdata,
  input  logic              s_hready,
  input  logic              s_hresp,
  input  logic              s_hexokay,
  input  logic [W_DATA-1:0] s_hrdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } own_e;

  typedef struct packed {
    logic [W_ADDR-1:0] haddr;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [3:0]        hprot;
    logic              hmastlock;
    logic              hexcl;
  } req_t;

  req_t       live [2];
  req_t       bufr [2];
  req_t       g;
  logic [1:0] buf_vld;
  logic [1:0] live_vld;
  logic [1:0] allow;
  logic [1:0] cb;
  logic [1:0] cl;
  logic [1:0] cand;
  logic       rr_ptr;
  logic       lock_vld;
  logic       lock_id;
  logic       gnt_vld;
  logic       gbuf;
  logic       gid;
  logic       take_live;
  logic       take_buf;
  own_e       owner;

  assign live[0] = {m0_haddr, m0_hwrite, m0_hsize, m0_hburst,
                    m0_hprot, m0_hmastlock, m0_hexcl};
  assign live[1] = {m1_haddr, m1_hwrite, m1_hsize, m1_hburst,
                    m1_hprot, m1_hmastlock, m1_hexcl};

  // A full buffer stalls its master before any owner consideration
  always_comb begin
    m0_hready = 1'b1;
    m1_hready = 1'b1;
    if (buf_vld[0])
      m0_hready = 1'b0;
    else if (owner == OWN_M0)
      m0_hready = s_hready;
    if (buf_vld[1])
      m1_hready = 1'b0;
    else if (owner == OWN_M1)
      m1_hready = s_hready;
  end

  assign live_vld[0] = rst_n & m0_hready & m0_htrans[1];
  assign live_vld[1] = rst_n & m1_hready & m1_htrans[1];

  always_comb begin
    allow = 2'b11;
    if (lock_vld)
      allow = lock_id ? 2'b10 : 2'b01;
    cb   = buf_vld & allow;
    cl   = live_vld & allow;
    gbuf = |cb;
    cand = gbuf ? cb : cl;
    gid  = (cand == 2'b11) ? rr_ptr : cand[1];
    g    = gbuf ? bufr[gid] : live[gid];
  end

  assign gnt_vld   = rst_n & s_hready & (|cand);
  assign take_live = gnt_vld & ~gbuf;
  assign take_buf  = gnt_vld & gbuf;

  assign s_htrans    = gnt_vld ? 2'b10 : 2'b00;
  assign s_haddr     = g.haddr;
  assign s_hwrite    = g.hwrite;
  assign s_hsize     = g.hsize;
  assign s_hburst    = g.hburst;
  assign s_hprot     = g.hprot;
  assign s_hmastlock = g.hmastlock;
  assign s_hexcl     = g.hexcl;

  always_comb begin
    s_hwdata = '0;
    unique case (1'b1)
      owner == OWN_M0: s_hwdata = m0_hwdata;
      owner == OWN_M1: s_hwdata = m1_hwdata;
      default:         s_hwdata = '0;
    endcase
  end

  assign m0_hresp   = (owner == OWN_M0) & s_hresp;
  assign m1_hresp   = (owner == OWN_M1) & s_hresp;
  assign m0_hexokay = (owner == OWN_M0) & s_hexokay;
  assign m1_hexokay = (owner == OWN_M1) & s_hexokay;
  assign m0_hrdata  = s_hrdata;
  assign m1_hrdata  = s_hrdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_vld  <= 2'b00;
      bufr[0]  <= '0;
      bufr[1]  <= '0;
      rr_ptr   <= 1'b0;
      lock_vld <= 1'b0;
      lock_id  <= 1'b0;
      owner    <= OWN_NONE;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (live_vld[i] && !(take_live && gid == 1'(i))) begin
          buf_vld[i] <= 1'b1;
          bufr[i]    <= live[i];
        end else if (take_buf && gid == 1'(i)) begin
          buf_vld[i] <= 1'b0;
        end
      end
      if (s_hready) begin
        owner <= gnt_vld ? (gid ? OWN_M1 : OWN_M0) : OWN_NONE;
        // No grant while locked means the holder went idle
        if (gnt_vld) begin
          rr_ptr   <= ~gid;
          lock_vld <= g.hmastlock;
          lock_id  <= gid;
        end else begin
          lock_vld <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahbl_arbiter_2m.sv
// tb_ahbl_arbiter_2m: directed stimulus, grant scoreboard,
// plus timing checks on handshake and response routing.
module tb_ahbl_arbiter_2m;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] NSEQ = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m0_haddr, m1_haddr, s_haddr;
  logic        m0_hwrite, m1_hwrite, s_hwrite;
  logic [1:0]  m0_htrans, m1_htrans, s_htrans;
  logic        m0_hexcl, m1_hexcl, s_hexcl;
  logic [2:0]  m0_hsize, m1_hsize, s_hsize;
  logic [2:0]  m0_hburst, m1_hburst, s_hburst;
  logic [3:0]  m0_hprot, m1_hprot, s_hprot;
  logic        m0_hmastlock, m1_hmastlock, s_hmastlock;
  logic [31:0] m0_hwdata, m1_hwdata, s_hwdata;
  logic        m0_hready, m1_hready, s_hready;
  logic        m0_hresp, m1_hresp, s_hresp;
  logic        m0_hexokay, m1_hexokay, s_hexokay;
  logic [31:0] m0_hrdata, m1_hrdata, s_hrdata;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic        lk;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  ahbl_arbiter_2m #(.W_ADDR(32), .W_DATA(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite), .m0_htrans(m0_htrans),
    .m0_hexcl(m0_hexcl), .m0_hsize(m0_hsize), .m0_hburst(m0_hburst),
    .m0_hprot(m0_hprot), .m0_hmastlock(m0_hmastlock),
    .m0_hwdata(m0_hwdata), .m0_hready(m0_hready), .m0_hresp(m0_hresp),
    .m0_hexokay(m0_hexokay), .m0_hrdata(m0_hrdata),
    .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite), .m1_htrans(m1_htrans),
    .m1_hexcl(m1_hexcl), .m1_hsize(m1_hsize), .m1_hburst(m1_hburst),
    .m1_hprot(m1_hprot), .m1_hmastlock(m1_hmastlock),
    .m1_hwdata(m1_hwdata), .m1_hready(m1_hready), .m1_hresp(m1_hresp),
    .m1_hexokay(m1_hexokay), .m1_hrdata(m1_hrdata),
    .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_htrans(s_htrans),
    .s_hexcl(s_hexcl), .s_hsize(s_hsize), .s_hburst(s_hburst),
    .s_hprot(s_hprot), .s_hmastlock(s_hmastlock), .s_hwdata(s_hwdata),
    .s_hready(s_hready), .s_hresp(s_hresp), .s_hexokay(s_hexokay),
    .s_hrdata(s_hrdata)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, req);
  endtask

  task automatic push(input logic [31:0] a, input logic w,
                      input logic l);
    exp_t e;
    e.addr = a;
    e.wr   = w;
    e.lk   = l;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req0(input logic [31:0] a, input logic w,
                      input logic l);
    m0_htrans    = NSEQ;
    m0_haddr     = a;
    m0_hwrite    = w;
    m0_hmastlock = l;
  endtask

  task automatic req1(input logic [31:0] a, input logic w,
                      input logic l);
    m1_htrans    = NSEQ;
    m1_haddr     = a;
    m1_hwrite    = w;
    m1_hmastlock = l;
  endtask

  task automatic idle();
    m0_htrans    = IDLE;
    m1_htrans    = IDLE;
    m0_hmastlock = 1'b0;
    m1_hmastlock = 1'b0;
  endtask

  // Every granted slave address phase must match the next expectation
  always @(negedge clk) begin
    if (rst_n && s_hready && s_htrans == NSEQ) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_grant: got addr %0h want none",
                 s_haddr);
      end else begin
        mon_e = exp_q.pop_front();
        chk("grant_addr", 64'(s_haddr), 64'(mon_e.addr));
        chk("grant_write", 64'(s_hwrite), 64'(mon_e.wr));
        chk("grant_lock", 64'(s_hmastlock), 64'(mon_e.lk));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int   n0;
    int   n1;
    logic a0;
    logic a1;
    rst_n = 1'b0;
    idle();
    m0_haddr = '0; m1_haddr = '0;
    m0_hwrite = 1'b0; m1_hwrite = 1'b0;
    m0_hexcl = 1'b0; m1_hexcl = 1'b0;
    m0_hsize = 3'b010; m1_hsize = 3'b010;
    m0_hburst = 3'b000; m1_hburst = 3'b000;
    m0_hprot = 4'b0011; m1_hprot = 4'b0011;
    m0_hwdata = 32'h1111_1111;
    m1_hwdata = 32'hDEAD_BEEF;
    s_hready = 1'b1;
    s_hresp = 1'b1;
    s_hexokay = 1'b0;
    s_hrdata = 32'h0;
    m0_htrans = NSEQ;

    // Reset state, with a live request and slave error present
    #2;
    chk("rst_htrans", 64'(s_htrans), 64'(IDLE));
    chk("rst_m0_hready", 64'(m0_hready), 64'd1);
    chk("rst_m1_hready", 64'(m1_hready), 64'd1);
    chk("rst_m0_hresp", 64'(m0_hresp), 64'd0);
    chk("rst_hwdata", 64'(s_hwdata), 64'd0);
    step();
    rst_n = 1'b1;
    s_hresp = 1'b0;
    idle();
    step();

    // Single master: zero-latency pass-through
    req0(32'h100, 1'b0, 1'b0);
    push(32'h100, 1'b0, 1'b0);
    @(negedge clk);
    chk("single_htrans", 64'(s_htrans), 64'(NSEQ));
    chk("single_haddr", 64'(s_haddr), 64'h100);
    chk("single_m1_hready", 64'(m1_hready), 64'd1);
    step();
    idle();
    s_hrdata = 32'hA5A5_0001;
    @(negedge clk);
    chk("single_m0_hrdata", 64'(m0_hrdata), 64'hA5A5_0001);
    chk("single_m1_hrdata", 64'(m1_hrdata), 64'hA5A5_0001);
    chk("single_m0_hready", 64'(m0_hready), 64'd1);
    chk("single_m1_hready2", 64'(m1_hready), 64'd1);
    step();
    req1(32'h104, 1'b0, 1'b0);
    push(32'h104, 1'b0, 1'b0);
    step();
    idle();
    step();

    // Contention: m0 preferred, m1 write buffered one cycle
    req0(32'h100, 1'b0, 1'b0);
    req1(32'h200, 1'b1, 1'b0);
    push(32'h100, 1'b0, 1'b0);
    push(32'h200, 1'b1, 1'b0);
    @(negedge clk);
    chk("cont_first_haddr", 64'(s_haddr), 64'h100);
    chk("cont_m1_accept", 64'(m1_hready), 64'd1);
    step();
    idle();
    @(negedge clk);
    chk("cont_second_haddr", 64'(s_haddr), 64'h200);
    chk("cont_second_htrans", 64'(s_htrans), 64'(NSEQ));
    chk("cont_m1_stall", 64'(m1_hready), 64'd0);
    chk("cont_m0_hready", 64'(m0_hready), 64'd1);
    chk("cont_m0_wdata", 64'(s_hwdata), 64'h1111_1111);
    step();
    @(negedge clk);
    chk("cont_m1_wdata", 64'(s_hwdata), 64'hDEAD_BEEF);
    chk("cont_m1_release", 64'(m1_hready), 64'd1);
    step();

    // Round-robin: both masters stream four reads each
    push(32'h1000, 1'b0, 1'b0); push(32'h2000, 1'b0, 1'b0);
    push(32'h1004, 1'b0, 1'b0); push(32'h2004, 1'b0, 1'b0);
    push(32'h1008, 1'b0, 1'b0); push(32'h2008, 1'b0, 1'b0);
    push(32'h100C, 1'b0, 1'b0); push(32'h200C, 1'b0, 1'b0);
    n0 = 0;
    n1 = 0;
    for (int c = 0; c < 20 && (n0 < 4 || n1 < 4); c++) begin
      m0_htrans = (n0 < 4) ? NSEQ : IDLE;
      m1_htrans = (n1 < 4) ? NSEQ : IDLE;
      m0_haddr  = 32'h1000 + 32'(n0 * 4);
      m1_haddr  = 32'h2000 + 32'(n1 * 4);
      m0_hwrite = 1'b0;
      m1_hwrite = 1'b0;
      @(negedge clk);
      a0 = m0_hready && (n0 < 4);
      a1 = m1_hready && (n1 < 4);
      step();
      if (a0) n0++;
      if (a1) n1++;
    end
    idle();
    step();
    step();
    chk("rr_m0_count", 64'(n0), 64'd4);
    chk("rr_m1_count", 64'(n1), 64'd4);
    chk("rr_drained", 64'(exp_q.size()), 64'd0);

    // Wait states: m1 parked, issued when s_hready returns
    req0(32'h300, 1'b0, 1'b0);
    push(32'h300, 1'b0, 1'b0);
    step();
    idle();
    req1(32'h400, 1'b0, 1'b0);
    push(32'h400, 1'b0, 1'b0);
    s_hready = 1'b0;
    @(negedge clk);
    chk("ws_htrans_idle", 64'(s_htrans), 64'(IDLE));
    chk("ws_m0_stall", 64'(m0_hready), 64'd0);
    chk("ws_m1_accept", 64'(m1_hready), 64'd1);
    step();
    idle();
    @(negedge clk);
    chk("ws_m1_buffered", 64'(m1_hready), 64'd0);
    chk("ws_htrans_idle2", 64'(s_htrans), 64'(IDLE));
    step();
    step();
    s_hready = 1'b1;
    @(negedge clk);
    chk("ws_issue_htrans", 64'(s_htrans), 64'(NSEQ));
    chk("ws_issue_haddr", 64'(s_haddr), 64'h400);
    chk("ws_m0_done", 64'(m0_hready), 64'd1);
    step();

    // Two-cycle ERROR on m1's data phase
    req1(32'h500, 1'b0, 1'b0);
    push(32'h500, 1'b0, 1'b0);
    step();
    idle();
    s_hready = 1'b0;
    s_hresp = 1'b1;
    @(negedge clk);
    chk("err1_m1_hresp", 64'(m1_hresp), 64'd1);
    chk("err1_m1_hready", 64'(m1_hready), 64'd0);
    chk("err1_m0_hresp", 64'(m0_hresp), 64'd0);
    step();
    s_hready = 1'b1;
    @(negedge clk);
    chk("err2_m1_hresp", 64'(m1_hresp), 64'd1);
    chk("err2_m1_hready", 64'(m1_hready), 64'd1);
    chk("err2_m0_hresp", 64'(m0_hresp), 64'd0);
    step();
    s_hresp = 1'b0;
    req0(32'h600, 1'b0, 1'b0);
    push(32'h600, 1'b0, 1'b0);
    @(negedge clk);
    chk("err_after_haddr", 64'(s_haddr), 64'h600);
    chk("err_after_m1_hresp", 64'(m1_hresp), 64'd0);
    step();
    idle();
    step();

    // Locked m0 keeps the bus although m1 holds priority
    req0(32'h700, 1'b0, 1'b1);
    push(32'h700, 1'b0, 1'b1);
    step();
    req0(32'h704, 1'b0, 1'b0);
    req1(32'h800, 1'b0, 1'b0);
    push(32'h704, 1'b0, 1'b0);
    push(32'h800, 1'b0, 1'b0);
    @(negedge clk);
    chk("lock_hold_haddr", 64'(s_haddr), 64'h704);
    step();
    idle();
    @(negedge clk);
    chk("lock_release_haddr", 64'(s_haddr), 64'h800);
    step();
    step();

    // Reset while m1 sits in its buffer
    req0(32'h900, 1'b0, 1'b0);
    req1(32'hA00, 1'b0, 1'b0);
    push(32'h900, 1'b0, 1'b0);
    @(negedge clk);
    chk("rmid_first_haddr", 64'(s_haddr), 64'h900);
    step();
    idle();
    #1;
    chk("rmid_m1_buffered", 64'(m1_hready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("rmid_m1_hready", 64'(m1_hready), 64'd1);
    chk("rmid_htrans", 64'(s_htrans), 64'(IDLE));
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rmid_no_stale", 64'(s_htrans), 64'(IDLE));
      step();
    end

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
